// File: rtl/irq_ctrl_if.sv
// Register-window bus between the BIFROST register decoder and irq_ctrl.
//   reg_addr : register select (0 STATUS, 1 PENDING, 2 MASK, 3 MODE, 4 ID, 5-7 unused)
//   wr_en    : single-cycle write strobe, already qualified by chip select and rw low
//   wdata    : write data, sampled while wr_en is high
//   rdata    : combinational read data for reg_addr
// master = register decoder / CPU side, slave = irq_ctrl.
interface irq_ctrl_if;
  logic [2:0] reg_addr;
  logic       wr_en;
  logic [7:0] wdata;
  logic [7:0] rdata;

  modport master (
    output reg_addr,
    output wr_en,
    output wdata,
    input  rdata
  );

  modport slave (
    input  reg_addr,
    input  wr_en,
    input  wdata,
    output rdata
  );
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt controller between the BIFROST peripheral IRQ lines and the 6502 IRQB pin.
// Synchronises eight active-low requests, latches each as level or edge, applies an
// enable mask and drives a registered active-low irq_n.
//   clock : system clock (CPU phase), rising edge only
//   reset : asynchronous, active-high; clears all state and forces irq_n high at once
//   src_n : active-low requests (0 via1, 1 via2, 2 uart, 3 uart_txa, 4 uart_rxa,
//           5 uart_txb, 6 uart_rxb, 7 spare)
//   bus   : register window (see irq_ctrl_if); reads are side-effect free
//   irq_n : registered active-low interrupt to the CPU
// The register layout is fixed for NSRC = 8; SYNC_STAGES must be at least 2.
module irq_ctrl #(
  parameter int unsigned NSRC        = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NSRC-1:0] src_n,
  irq_ctrl_if.slave       bus,
  output logic            irq_n
);

  localparam logic [2:0] AddrStatus  = 3'd0;
  localparam logic [2:0] AddrPending = 3'd1;
  localparam logic [2:0] AddrMask    = 3'd2;
  localparam logic [2:0] AddrMode    = 3'd3;
  localparam logic [2:0] AddrId      = 3'd4;

  // Synchroniser holds active-high request, so its reset value of 0 means "not requesting".
  logic [SYNC_STAGES-1:0][NSRC-1:0] sync_q, sync_d;
  logic [NSRC-1:0] req;
  logic [NSRC-1:0] req_prev_q, req_prev_d;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] mask_q, mask_d;
  logic [NSRC-1:0] mode_q, mode_d;
  logic            irq_n_q, irq_n_d;

  logic [NSRC-1:0] edge_det;
  logic [NSRC-1:0] w1c;
  logic [NSRC-1:0] mode_chg;
  logic [NSRC-1:0] enabled;
  logic            id_active;
  logic [2:0]      id_idx;

  assign req      = sync_q[SYNC_STAGES-1];
  // req_prev_q resets to 0 alongside the synchroniser, so no edge fires on reset release.
  assign edge_det = req & ~req_prev_q;
  assign enabled  = pending_q & mask_q;

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], ~src_n};
    req_prev_d = req;
  end

  // Register writes.
  always_comb begin
    w1c      = '0;
    mode_chg = '0;
    mask_d   = mask_q;
    mode_d   = mode_q;
    if (bus.wr_en) begin
      case (bus.reg_addr)
        AddrPending: w1c = bus.wdata;
        AddrMask:    mask_d = bus.wdata;
        AddrMode: begin
          mode_d   = bus.wdata;
          mode_chg = bus.wdata ^ mode_q;
        end
        default: ;
      endcase
    end
  end

  // Level bits track req; edge bits set on an edge (set beats W1C); a mode change clears
  // the bit for the write cycle so it restarts cleanly in its new mode.
  always_comb begin
    pending_d = (~mode_q & req) | (mode_q & ((pending_q & ~w1c) | edge_det));
    pending_d = pending_d & ~mode_chg;
    irq_n_d   = ~|enabled;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q     <= '0;
      req_prev_q <= '0;
      pending_q  <= '0;
      mask_q     <= '0;
      mode_q     <= '0;
      irq_n_q    <= 1'b1;
    end else begin
      sync_q     <= sync_d;
      req_prev_q <= req_prev_d;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      mode_q     <= mode_d;
      irq_n_q    <= irq_n_d;
    end
  end

  assign irq_n = irq_n_q;

  // Lowest-numbered enabled pending bit wins; scan high to low so the last hit is the lowest.
  always_comb begin
    id_active = |enabled;
    id_idx    = 3'd0;
    for (int i = int'(NSRC) - 1; i >= 0; i--) begin
      if (enabled[i]) id_idx = 3'(i);
    end
  end

  always_comb begin
    bus.rdata = 8'h00;
    case (bus.reg_addr)
      AddrStatus:  bus.rdata = req;
      AddrPending: bus.rdata = pending_q;
      AddrMask:    bus.rdata = mask_q;
      AddrMode:    bus.rdata = mode_q;
      AddrId:      bus.rdata = {id_active, 4'b0000, id_idx};
      default:     bus.rdata = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed stimulus, literal expectations and a
// per-cycle comparison against a behavioural model built on a delay-line of requests.
module tb_irq_ctrl;
  localparam int SyncStages = 2;

  logic       clock;
  logic       reset;
  logic [7:0] src_n;
  logic       irq_n;
  int         checks;
  int         errors;

  irq_ctrl_if bus_if ();

  irq_ctrl #(
    .NSRC       (8),
    .SYNC_STAGES(SyncStages)
  ) dut (
    .clock(clock),
    .reset(reset),
    .src_n(src_n),
    .bus  (bus_if),
    .irq_n(irq_n)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h want %02h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] line_q[$];   // last SyncStages active-high samples of the request pins
  logic [7:0] m_req, m_req_old, m_pend, m_mask, m_mode, m_np;
  logic       m_irq;

  always @(posedge clock) begin
    if (reset) begin
      line_q = {};
      for (int s = 0; s < SyncStages; s++) line_q.push_back(8'h00);
      m_req = 0; m_req_old = 0; m_pend = 0; m_mask = 0; m_mode = 0; m_irq = 1'b1;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (bus_if.wr_en && bus_if.reg_addr == 3 && bus_if.wdata[i] != m_mode[i]) m_np[i] = 0;
        else if (!m_mode[i]) m_np[i] = m_req[i];
        else if (m_req[i] && !m_req_old[i]) m_np[i] = 1;
        else if (bus_if.wr_en && bus_if.reg_addr == 1 && bus_if.wdata[i]) m_np[i] = 0;
        else m_np[i] = m_pend[i];
      end
      m_irq = ((m_pend & m_mask) == 8'h00);
      if (bus_if.wr_en && bus_if.reg_addr == 2) m_mask = bus_if.wdata;
      if (bus_if.wr_en && bus_if.reg_addr == 3) m_mode = bus_if.wdata;
      m_pend = m_np;
      line_q.push_back(~src_n);
      void'(line_q.pop_front());
      m_req_old = m_req;
      m_req = line_q[0];
    end
  end

  function automatic logic [7:0] exp_rd(input logic [2:0] a);
    logic [7:0] en;
    en = m_pend & m_mask;
    case (a)
      3'd0: return m_req;
      3'd1: return m_pend;
      3'd2: return m_mask;
      3'd3: return m_mode;
      3'd4: begin
        for (int i = 0; i < 8; i++) if (en[i]) return 8'h80 | 8'(i);
        return 8'h00;
      end
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clock) begin
    #2;
    chk("model irq_n", {7'd0, irq_n}, {7'd0, m_irq});
    chk("model rdata", bus_if.rdata, exp_rd(bus_if.reg_addr));
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic rd(input logic [2:0] a, input logic [7:0] exp, input string name);
    bus_if.reg_addr = a;
    #1;
    chk(name, bus_if.rdata, exp);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clock);
    bus_if.reg_addr = a;
    bus_if.wdata    = d;
    bus_if.wr_en    = 1'b1;
    @(negedge clock);
    bus_if.wr_en    = 1'b0;
  endtask

  task automatic chk_irq(input logic exp, input string name);
    chk(name, {7'd0, irq_n}, {7'd0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    src_n  = 8'hFF;
    bus_if.reg_addr = 3'd0;
    bus_if.wr_en    = 1'b0;
    bus_if.wdata    = 8'h00;
    cyc(2);
    reset = 1'b0;
    cyc(1);

    // Reset state: every register reads zero, irq_n high.
    for (int a = 0; a < 8; a++) rd(3'(a), 8'h00, "reset read");
    chk_irq(1'b1, "reset irq_n");

    // STATUS follows the synchronised input two edges later.
    @(negedge clock);
    src_n = 8'h7F;
    cyc(2);
    rd(3'd0, 8'h80, "status spare");
    src_n = 8'hFF;
    cyc(4);
    rd(3'd1, 8'h00, "status pending gone");

    // Level mode on uart (bit 2).
    wr(3'd2, 8'h04);
    src_n = 8'hFB;
    cyc(3);
    chk_irq(1'b1, "level irq_n k+2");
    cyc(1);
    chk_irq(1'b0, "level irq_n k+3");
    rd(3'd4, 8'h82, "level id");
    wr(3'd1, 8'h04);
    rd(3'd1, 8'h04, "level w1c ignored");
    src_n = 8'hFF;
    cyc(3);
    chk_irq(1'b0, "level release k+2");
    cyc(1);
    chk_irq(1'b1, "level release k+3");

    // Edge mode on via1 (bit 0).
    wr(3'd2, 8'h01);
    wr(3'd3, 8'h01);
    src_n = 8'hFE;
    cyc(2);
    src_n = 8'hFF;
    cyc(4);
    rd(3'd1, 8'h01, "edge pending");
    chk_irq(1'b0, "edge irq held");
    wr(3'd1, 8'h01);
    rd(3'd1, 8'h00, "edge w1c");
    chk_irq(1'b0, "edge irq k");
    cyc(1);
    chk_irq(1'b1, "edge irq k+1");

    // Masking and priority.
    wr(3'd2, 8'h00);
    wr(3'd3, 8'hFF);
    src_n = 8'hDD;
    cyc(2);
    src_n = 8'hFF;
    cyc(4);
    chk_irq(1'b1, "masked irq_n");
    rd(3'd1, 8'h22, "prio pending");
    rd(3'd4, 8'h00, "prio id none");
    wr(3'd2, 8'h20);
    rd(3'd4, 8'h85, "prio id 5");
    wr(3'd2, 8'h22);
    rd(3'd4, 8'h81, "prio id 1");
    wr(3'd1, 8'h02);
    rd(3'd4, 8'h85, "prio id 5 again");
    rd(3'd1, 8'h20, "prio pending after clr");
    cyc(1);
    chk_irq(1'b0, "prio irq_n");

    // Set and clear on the same edge: set wins.
    src_n = 8'hF7;
    cyc(2);
    src_n = 8'hFF;
    cyc(4);
    rd(3'd1, 8'h28, "bit3 pending");
    src_n = 8'hF7;
    cyc(2);
    src_n = 8'hFF;
    bus_if.reg_addr = 3'd1;
    bus_if.wdata    = 8'h08;
    bus_if.wr_en    = 1'b1;
    @(negedge clock);
    bus_if.wr_en    = 1'b0;
    rd(3'd1, 8'h28, "set wins");
    wr(3'd1, 8'h08);
    rd(3'd1, 8'h20, "bit3 cleared");

    // Mode change clears the bit on the write edge, then level takes over.
    wr(3'd1, 8'h20);
    rd(3'd1, 8'h00, "all clear");
    src_n = 8'hBF;
    cyc(4);
    rd(3'd1, 8'h40, "bit6 edge pending");
    wr(3'd3, 8'hBF);
    rd(3'd1, 8'h00, "mode change clears");
    rd(3'd3, 8'hBF, "mode readback");
    cyc(1);
    rd(3'd1, 8'h40, "bit6 level follows");

    // Asynchronous reset mid-interrupt.
    wr(3'd2, 8'h40);
    cyc(2);
    chk_irq(1'b0, "pre-reset irq_n");
    #1;
    reset = 1'b1;
    #1;
    chk_irq(1'b1, "async reset irq_n");
    rd(3'd2, 8'h00, "async reset mask");
    @(negedge clock);
    reset = 1'b0;
    src_n = 8'hFF;
    cyc(4);
    rd(3'd1, 8'h00, "post-reset pending");
    chk_irq(1'b1, "post-reset irq_n");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
